perf_snapshot_unit: RTL
=======================

Name: perf_snapshot_unit

Overview:
Sits between the CSR file and perf_counters, on the consumer side of the counters' SRAM-like read/write port.
- CSR accesses pass straight through to the counters, with priority.
- On a snapshot request, the block walks every performance counter one per cycle and buffers each value in a small FIFO.
- The buffered values drain over a valid/ready stream to the debug/trace consumer, with optional clear-on-snapshot.

Parameters:
NR_COUNTERS, 14, number of consecutive counters walked (1..32)
START_ADDR, 5'd3, 5-bit counter address of the first counter walked
FIFO_DEPTH, 4, snapshot buffer entries (power of two, >=2)
CLEAR_ON_SNAP, 1'b0, when 1 each counter is written to zero in the same cycle it is read

Ports:
clk_i  in  1  clock
rst_i  in  1  reset (see interface note)
csr_req_i  in  1  CSR access to a perf counter this cycle
csr_addr_i  in  5  CSR counter address
csr_we_i  in  1  CSR write enable
csr_wdata_i  in  64  CSR write data
csr_rdata_o  out  64  CSR read data
perf_addr_o  out  5  to perf_counters addr_i
perf_we_o  out  1  to perf_counters we_i
perf_data_o  out  64  to perf_counters data_i
perf_data_i  in  64  from perf_counters data_o (combinational read)
snap_req_i  in  1  single-cycle snapshot request
snap_busy_o  out  1  snapshot in progress
snap_overrun_o  out  1  sticky: request dropped while busy
out_valid_o  out  1  stream valid
out_ready_i  in  1  stream ready
out_data_o  out  64  counter value
out_idx_o  out  5  counter address of out_data_o
out_last_o  out  1  final counter of this snapshot

Behaviour:
Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.

Reset:
- FSM goes to IDLE; FIFO is emptied; walk index is 0.
- snap_busy_o=0, snap_overrun_o=0, out_valid_o=0.
- perf_we_o=0, perf_addr_o=0 (no csr_req_i), out_* data=0.
- Reset mid-snapshot aborts the walk and discards all buffered entries.

Port mux (combinational):
- When csr_req_i=1: perf_addr_o/we_o/data_o = csr_addr_i/csr_we_i/csr_wdata_i.
- csr_rdata_o = perf_data_i at all times.
- CSR always wins; the snapshot stalls that cycle.

FSM states IDLE, READ, DRAIN:
- IDLE:
  - snap_req_i=1 -> READ; idx<=0; snap_overrun_o<=0; snap_busy_o=1 from the next cycle.
  - Any FIFO remnants cannot exist in IDLE.
- READ:
  - A read slot occurs when csr_req_i=0 and FIFO count<FIFO_DEPTH (registered count; no push-while-full even if a pop happens).
  - In a read slot: perf_addr_o=START_ADDR+idx (5-bit wrap); push {perf_data_i, addr, last=(idx==NR_COUNTERS-1)}; idx++.
  - If CLEAR_ON_SNAP: perf_we_o=1 and perf_data_o=0 in the same slot. Value is read before the write; an increment in that cycle is lost by design.
  - Not a read slot: idx holds, perf_we_o follows the CSR mux or is 0.
  - After pushing the last entry -> DRAIN.
- DRAIN: when the FIFO is empty (last entry popped) -> IDLE; snap_busy_o=0 in IDLE.

snap_busy_o is 1 in READ and DRAIN.

snap_req_i while busy:
- Ignored; snap_overrun_o<=1.
- Sticky until the next accepted request.

Output stream:
- out_valid_o = FIFO non-empty; out_data_o, out_idx_o and out_last_o come from the head entry.
- Pop on out_valid_o & out_ready_i.
- Head fields hold while valid & !ready.
- Push and pop in the same cycle are allowed when count<FIFO_DEPTH.

Latency:
- Request at cycle 0 gives first read slot at cycle 1; out_valid_o at cycle 2.
- With no stalls, last push at cycle NR_COUNTERS.

Ordering: entries emerge in address order START_ADDR..START_ADDR+NR_COUNTERS-1. Exactly one entry has out_last_o=1 per snapshot.

Test Plan:
- Preload counters 3..16 with value 100+addr; pulse snap_req_i; out_ready_i=1 -> 14 beats, idx 3..16, data 103..116, out_last_o only on idx 16; snap_busy_o falls the cycle after the last pop.
- Same as above with out_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH=4 entries buffered, perf reads stall at idx 4; then ready=1 -> all 14 values delivered in order, none lost or duplicated.
- csr_req_i=1 write 64'hDEAD to addr 5 during READ at idx 2 -> perf port shows the CSR access that cycle, idx holds; snapshot later reports 64'hDEAD for idx 5.
- CLEAR_ON_SNAP=1, counters all 7 -> every beat reports 7; afterwards all counters read 0 via CSR.
- snap_req_i pulsed again mid-snapshot -> snap_overrun_o=1, only 14 beats produced; the next accepted request clears it.
- rst_i asserted after 5 beats pushed -> next cycle out_valid_o=0, snap_busy_o=0, FSM IDLE; a new request restarts at idx 3.

Source files
------------

// File: rtl/perf_snapshot_unit.sv
// rtl/perf_snapshot_unit.sv - perf counter snapshot walker with CSR passthrough and output FIFO
module perf_snapshot_unit #(
  parameter int unsigned NR_COUNTERS   = 14,
  parameter logic [4:0]  START_ADDR    = 5'd3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          CLEAR_ON_SNAP = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_req_i,
  input  logic [4:0]  csr_addr_i,
  input  logic        csr_we_i,
  input  logic [63:0] csr_wdata_i,
  output logic [63:0] csr_rdata_o,
  output logic [4:0]  perf_addr_o,
  output logic        perf_we_o,
  output logic [63:0] perf_data_o,
  input  logic [63:0] perf_data_i,
  input  logic        snap_req_i,
  output logic        snap_busy_o,
  output logic        snap_overrun_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic [4:0]  out_idx_o,
  output logic        out_last_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic                overrun_q;
  logic [63:0]         fifo_data [FIFO_DEPTH];
  logic [4:0]          fifo_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         count_q;
  logic                fifo_empty, read_slot, is_last, push, pop;
  logic [4:0]          rd_addr;

  assign fifo_empty = (count_q == '0);
  // Full check uses the registered count so a same-cycle pop never frees a slot early.
  assign read_slot  = (state_q == READ) && !csr_req_i && (count_q < DEPTH_C);
  assign rd_addr    = START_ADDR + idx_q[4:0];
  assign is_last    = (idx_q == 6'(NR_COUNTERS - 1));
  assign push       = read_slot;
  assign pop        = !fifo_empty && out_ready_i;

  always_comb begin
    perf_addr_o = '0;
    perf_we_o   = 1'b0;
    perf_data_o = '0;
    if (csr_req_i) begin
      perf_addr_o = csr_addr_i;
      perf_we_o   = csr_we_i;
      perf_data_o = csr_wdata_i;
    end else if (read_slot) begin
      perf_addr_o = rd_addr;
      perf_we_o   = CLEAR_ON_SNAP;
    end
  end

  assign csr_rdata_o = perf_data_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (snap_req_i) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        if (read_slot) begin
          idx_d = idx_q + 6'd1;
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the final entry is popped so busy drops the very next cycle.
        if (fifo_empty || (pop && count_q == ONE_C)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (snap_req_i) overrun_q <= (state_q != IDLE);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= perf_data_i;
      fifo_addr[wr_ptr_q] <= rd_addr;
      fifo_last[wr_ptr_q] <= is_last;
    end
  end

  assign snap_busy_o    = (state_q != IDLE);
  assign snap_overrun_o = overrun_q;
  assign out_valid_o    = !fifo_empty;
  assign out_data_o     = fifo_empty ? '0   : fifo_data[rd_ptr_q];
  assign out_idx_o      = fifo_empty ? '0   : fifo_addr[rd_ptr_q];
  assign out_last_o     = fifo_empty ? 1'b0 : fifo_last[rd_ptr_q];

endmodule
